// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM states and sync-character constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_UPDATE  = 2'd3
  } ab_state_e;

  // 0x55 framed LSB-first gives five falling edges spanning 8 bit times.
  localparam int unsigned SYNC_EDGES = 5;
  // 8 bit times x 16 oversample = 128 -> shift by 7, round with half of 128.
  localparam int unsigned OVS_SHIFT  = 7;
  localparam int unsigned ROUND      = 64;

endpackage

// File: rtl/autobaud_ctrl_if.sv
// Configuration and status bundle around the autobaud controller.
interface autobaud_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             cfg_wr;
  logic [DIV_W-1:0] cfg_div;
  logic             auto_start;
  logic             tick;
  logic [DIV_W-1:0] div;
  logic             div_upd;
  logic             busy;
  logic             locked;
  logic             err;

  modport master (
    output cfg_wr, cfg_div, auto_start,
    input  tick, div, div_upd, busy, locked, err
  );

  modport slave (
    input  cfg_wr, cfg_div, auto_start,
    output tick, div, div_upd, busy, locked, err
  );
endinterface

// File: rtl/baud_tick_gen.sv
// 16x oversample tick generator: period div+1, restartable by clr.
module baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count up to div, then wrap and flag a tick; clr restarts the period.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q >= div) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and registered tick output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/autobaud_ctrl.sv
// Autobaud controller: measures a 0x55 sync character and derives the
// 16x oversample divisor; software can override the divisor at any time.
module autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 325
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             auto_start,
  output logic             tick,
  output logic [DIV_W-1:0] div,
  output logic             div_upd,
  output logic             busy,
  output logic             locked,
  output logic             err
);

  localparam int C_W = DIV_W + OVS_SHIFT;
  localparam logic [2:0] LAST_EDGE = 3'(SYNC_EDGES - 1);

  ab_state_e        state_q, state_d;
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic             fall;
  logic [C_W-1:0]   c_q, c_d, c_lat_q, c_lat_d;
  logic [2:0]       edge_q, edge_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             div_upd_q, div_upd_d, busy_q, busy_d;
  logic             locked_q, locked_d, err_q, err_d;
  logic             tick_clr;
  logic [C_W:0]     sum;
  logic [DIV_W:0]   r, r_m1;
  logic             r_bad;

  // Rounded C/128; R-1 must be non-negative and fit the divisor width.
  assign sum   = {1'b0, c_lat_q} + (C_W + 1)'(ROUND);
  assign r     = (DIV_W + 1)'(sum >> OVS_SHIFT);
  assign r_m1  = r - 1'b1;
  assign r_bad = (r == '0) || r_m1[DIV_W];
  assign fall  = rx_prev_q & ~rx_sync_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; a software write aborts everything back to idle.
  always_comb begin
    state_d = state_q;
    if (cfg_wr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (auto_start) state_d = ST_ARMED;
        ST_ARMED:   if (fall) state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (c_q == '1)                       state_d = ST_IDLE;
          else if (fall && edge_q == LAST_EDGE) state_d = ST_UPDATE;
        end
        ST_UPDATE:  state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and measurement datapath.
  always_comb begin
    c_d       = c_q;
    c_lat_d   = c_lat_q;
    edge_d    = edge_q;
    div_d     = div_q;
    div_upd_d = 1'b0;
    locked_d  = locked_q;
    err_d     = err_q;
    tick_clr  = 1'b0;
    if (cfg_wr) begin
      div_d     = cfg_div;
      div_upd_d = 1'b1;
      locked_d  = 1'b0;
      err_d     = 1'b0;
      tick_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (auto_start) begin
            locked_d = 1'b0;
            err_d    = 1'b0;
          end
        end
        ST_ARMED: begin
          if (fall) begin
            c_d    = '0;
            edge_d = 3'd1;
          end
        end
        ST_MEASURE: begin
          c_d = c_q + 1'b1;
          if (c_q == '1) begin
            err_d = 1'b1;
          end else if (fall) begin
            edge_d = edge_q + 3'd1;
            // Latch the count including the edge cycle itself.
            if (edge_q == LAST_EDGE) c_lat_d = c_q + 1'b1;
          end
        end
        ST_UPDATE: begin
          if (r_bad) begin
            err_d = 1'b1;
          end else begin
            div_d     = r_m1[DIV_W-1:0];
            div_upd_d = 1'b1;
            locked_d  = 1'b1;
            tick_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ST_ARMED) || (state_d == ST_MEASURE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      c_q       <= '0;
      c_lat_q   <= '0;
      edge_q    <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      div_upd_q <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      c_q       <= c_d;
      c_lat_q   <= c_lat_d;
      edge_q    <= edge_d;
      div_q     <= div_d;
      div_upd_q <= div_upd_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (div_q),
    .clr     (tick_clr),
    .tick    (tick)
  );

  assign div     = div_q;
  assign div_upd = div_upd_q;
  assign busy    = busy_q;
  assign locked  = locked_q;
  assign err     = err_q;

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Scoreboard bench for autobaud_ctrl: stimulus pushes expected div/flag
// events, a monitor pops them on every div_upd pulse or err rise and also
// checks every tick interval against the expected divisor.
module tb_autobaud_ctrl;

  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 325;

  typedef struct {
    bit             upd;
    bit [DIV_W-1:0] div;
    bit             locked;
    bit             err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  always #5 clk = ~clk;

  autobaud_ctrl_if #(.DIV_W(DIV_W)) ab_if ();

  autobaud_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .cfg_wr     (ab_if.cfg_wr),
    .cfg_div    (ab_if.cfg_div),
    .auto_start (ab_if.auto_start),
    .tick       (ab_if.tick),
    .div        (ab_if.div),
    .div_upd    (ab_if.div_upd),
    .busy       (ab_if.busy),
    .locked     (ab_if.locked),
    .err        (ab_if.err)
  );

  // Narrow instance so the measurement counter saturates within the run.
  logic       s_rx = 1'b1, s_auto = 1'b0, s_cfg_wr = 1'b0;
  logic [7:0] s_cfg_div = 8'd0;
  logic       s_tick, s_upd, s_busy, s_locked, s_err;
  logic [7:0] s_div;
  int         s_upd_cnt = 0;

  autobaud_ctrl #(.DIV_W(8), .DEFAULT_DIV(20)) dut_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (s_rx),
    .cfg_wr     (s_cfg_wr),
    .cfg_div    (s_cfg_div),
    .auto_start (s_auto),
    .tick       (s_tick),
    .div        (s_div),
    .div_upd    (s_upd),
    .busy       (s_busy),
    .locked     (s_locked),
    .err        (s_err)
  );

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   model_div = DEF_DIV;
  int   cur_div = DEF_DIV;
  int   since = 0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: tick interval and scoreboard event checks.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      since    = 0;
      cur_div  = DEF_DIV;
      err_prev = 1'b0;
    end else begin
      since++;
      if (ab_if.tick) begin
        check("tick_period", since, cur_div + 1);
        since = 0;
      end
      if (ab_if.div_upd || (ab_if.err && !err_prev)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: actual div_upd=%0b err=%0b div=%0d, required no event",
                   ab_if.div_upd, ab_if.err, ab_if.div);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ev_div_upd", ab_if.div_upd, e.upd);
          check("ev_div", ab_if.div, e.div);
          check("ev_locked", ab_if.locked, e.locked);
          check("ev_err", ab_if.err, e.err);
          check("ev_busy", ab_if.busy, 0);
          if (e.upd) cur_div = int'(e.div);
        end
      end
      if (ab_if.div_upd) since = 0;
      err_prev = ab_if.err;
    end
  end

  initial forever begin
    @(negedge clk);
    if (s_upd) s_upd_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual time %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_cfg(input int v);
    sb.push_back('{1'b1, DIV_W'(v), 1'b0, 1'b0});
    model_div = v;
  endtask

  task automatic cfg_write(input int v);
    ab_if.cfg_div = DIV_W'(v);
    ab_if.cfg_wr  = 1'b1;
    push_cfg(v);
    @(negedge clk);
    ab_if.cfg_wr = 1'b0;
  endtask

  // 0x55 frame, LSB first with start/stop; optional cfg_wr at (bit, cycle).
  task automatic frame(input int p, input int cfg_bit, input int cfg_dly, input int cfg_v);
    logic [9:0] bits;
    bits = 10'b10_1010_1010;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int j = 0; j < p; j++) begin
        if (b == cfg_bit && j == cfg_dly) begin
          ab_if.cfg_div = DIV_W'(cfg_v);
          ab_if.cfg_wr  = 1'b1;
          push_cfg(cfg_v);
        end
        @(negedge clk);
        ab_if.cfg_wr = 1'b0;
      end
    end
    rx = 1'b1;
  endtask

  task automatic arm();
    ab_if.auto_start = 1'b1;
    @(negedge clk);
    ab_if.auto_start = 1'b0;
    check("busy_armed", ab_if.busy, 1);
    repeat (2) @(negedge clk);
  endtask

  // Reference: C = 8 bit periods, R = round(C/128), div = R-1 if it fits.
  task automatic autobaud(input int p);
    int c, r;
    c = 8 * p;
    r = (c + 64) / 128;
    if (r == 0 || r - 1 > (1 << DIV_W) - 1) begin
      sb.push_back('{1'b0, DIV_W'(model_div), 1'b0, 1'b1});
    end else begin
      sb.push_back('{1'b1, DIV_W'(r - 1), 1'b1, 1'b0});
      model_div = r - 1;
    end
    arm();
    frame(p, -1, 0, 0);
    repeat (8) @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n;
    ab_if.cfg_wr     = 1'b0;
    ab_if.cfg_div    = '0;
    ab_if.auto_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    check("rst_div", ab_if.div, DEF_DIV);
    check("rst_tick", ab_if.tick, 0);
    check("rst_div_upd", ab_if.div_upd, 0);
    check("rst_busy", ab_if.busy, 0);
    check("rst_locked", ab_if.locked, 0);
    check("rst_err", ab_if.err, 0);

    n = 0;
    do begin @(negedge clk); n++; end while (!ab_if.tick && n < 1000);
    check("first_tick_cycle", n, DEF_DIV + 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ab_if.tick && n < 1000);
    check("second_tick_gap", n, DEF_DIV + 1);

    repeat (37) @(negedge clk);
    cfg_write(9);
    n = 1;
    while (!ab_if.tick && n < 100) begin @(negedge clk); n++; end
    check("cfg_first_tick", n, 11);

    autobaud(160);
    check("locked_after_160", ab_if.locked, 1);
    autobaud(40);
    autobaud(60);
    autobaud(4);
    check("div_after_err", ab_if.div, 3);
    check("locked_after_err", ab_if.locked, 0);
    repeat (6) autobaud(int'($urandom_range(5, 250)));

    // Software write while measuring aborts the measurement.
    arm();
    frame(100, 5, 10, int'($urandom_range(1, 500)));
    repeat (8) @(negedge clk);
    check("busy_after_abort", ab_if.busy, 0);
    check("sb_abort", sb.size(), 0);

    // Simultaneous write and arm: the write wins, arm is dropped.
    n = int'($urandom_range(1, 500));
    ab_if.cfg_div    = DIV_W'(n);
    ab_if.cfg_wr     = 1'b1;
    ab_if.auto_start = 1'b1;
    push_cfg(n);
    @(negedge clk);
    ab_if.cfg_wr     = 1'b0;
    ab_if.auto_start = 1'b0;
    check("busy_cfg_start", ab_if.busy, 0);
    repeat (2) @(negedge clk);
    frame(60, -1, 0, 0);
    repeat (8) @(negedge clk);
    check("sb_cfg_start", sb.size(), 0);

    // Write landing in the UPDATE cycle: single pulse carrying cfg_div.
    arm();
    frame(100, 8, 3, 77);
    repeat (8) @(negedge clk);
    check("div_cfg_in_update", ab_if.div, 77);
    check("sb_cfg_update", sb.size(), 0);

    // Reset mid-measurement discards the measurement.
    arm();
    rx = 1'b0; repeat (50) @(negedge clk);
    rx = 1'b1; repeat (50) @(negedge clk);
    rx = 1'b0; repeat (20) @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    model_div = DEF_DIV;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    check("rst2_div", ab_if.div, DEF_DIV);
    check("rst2_busy", ab_if.busy, 0);
    check("rst2_locked", ab_if.locked, 0);
    repeat (700) @(negedge clk);
    check("sb_rst2", sb.size(), 0);

    // Timeout on the narrow instance: one edge, then line idles high.
    s_auto = 1'b1;
    @(negedge clk);
    s_auto = 1'b0;
    check("small_busy", s_busy, 1);
    repeat (2) @(negedge clk);
    s_rx = 1'b0;
    n = 0;
    while (!s_err && n < 40000) begin
      @(negedge clk);
      n++;
      if (n == 4) s_rx = 1'b1;
    end
    check("timeout_cycle", n, 32771);
    check("timeout_err", s_err, 1);
    repeat (2) @(negedge clk);
    check("timeout_busy", s_busy, 0);
    check("timeout_div", s_div, 20);
    check("timeout_locked", s_locked, 0);
    check("timeout_no_upd", s_upd_cnt, 0);

    repeat (20) @(negedge clk);
    check("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
